// File: rtl/vga_fb_writer.sv
// CPU-store to VGA SRAM bridge: stores landing in the framebuffer window are queued as
// 32-bit words and drained as two 16-bit pixel writes, low half first.
module vga_fb_writer #(
  parameter logic [31:0] BASEADDRESS = 32'h4000_0000,
  parameter int unsigned FbWords     = 153600,
  parameter int unsigned Depth       = 8
) (
  input  logic                     ACLK,
  input  logic                     RESET_N,
  input  logic [31:0]              DATA_I,
  input  logic [31:0]              ADDR,
  input  logic                     WRSTB,
  output logic                     STALL,
  output logic                     SRAM_WR_VALID,
  input  logic                     SRAM_WR_READY,
  output logic [19:0]              SRAM_WR_ADDR,
  output logic [15:0]              SRAM_WR_DATA,
  output logic                     OVERFLOW,
  input  logic                     CLR_FLAGS,
  output logic [$clog2(Depth):0]   FIFO_COUNT
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  // One past the last byte of the window, kept at 33 bits so the compare cannot wrap.
  localparam logic [32:0] WinEnd = {1'b0, BASEADDRESS} + 33'(FbWords) * 33'd4;

  typedef enum logic [1:0] {StIdle, StLow, StHigh} state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [50:0]       r_mem [Depth];
  logic [PtrW-1:0]   r_wptr;
  logic [PtrW-1:0]   r_rptr;
  logic [CntW-1:0]   r_count;
  logic              r_overflow;

  logic              w_hit;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic [31:0]       w_offset;
  logic [18:0]       w_index;
  logic [50:0]       w_head;
  logic [CntW-1:0]   w_count_d;
  logic              w_unused;

  assign w_hit = WRSTB && ({1'b0, ADDR} >= {1'b0, BASEADDRESS}) && ({1'b0, ADDR} < WinEnd) &&
                 (ADDR[1:0] == 2'b00);
  assign w_offset  = ADDR - BASEADDRESS;
  assign w_index   = w_offset[20:2];
  assign w_unused  = ^{w_offset[31:21], w_offset[1:0]};
  assign w_full    = (r_count == CntW'(Depth));
  assign w_pop     = (r_state == StHigh) && SRAM_WR_READY;
  // A full FIFO still accepts a hit when the head is retired in the same cycle.
  assign w_push    = w_hit && (!w_full || w_pop);
  assign w_drop    = w_hit && w_full && !w_pop;
  assign w_head    = r_mem[r_rptr];
  assign w_count_d = r_count + CntW'(w_push) - CntW'(w_pop);

  assign STALL      = w_full;
  assign OVERFLOW   = r_overflow;
  assign FIFO_COUNT = r_count;

  always_comb begin
    w_state_d     = r_state;
    SRAM_WR_VALID = 1'b0;
    SRAM_WR_ADDR  = 20'd0;
    SRAM_WR_DATA  = 16'd0;
    unique case (r_state)
      StIdle: begin
        if (r_count != '0) w_state_d = StLow;
      end
      StLow: begin
        SRAM_WR_VALID = 1'b1;
        SRAM_WR_ADDR  = {w_head[50:32], 1'b0};
        SRAM_WR_DATA  = w_head[15:0];
        if (SRAM_WR_READY) w_state_d = StHigh;
      end
      StHigh: begin
        SRAM_WR_VALID = 1'b1;
        SRAM_WR_ADDR  = {w_head[50:32], 1'b1};
        SRAM_WR_DATA  = w_head[31:16];
        if (SRAM_WR_READY) w_state_d = (w_count_d != '0) ? StLow : StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= StIdle;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_count <= w_count_d;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (CLR_FLAGS) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Storage needs no reset: outputs are gated by the state, and pointers restart at zero.
  always_ff @(posedge ACLK) begin
    if (w_push) r_mem[r_wptr] <= {w_index, DATA_I};
  end

endmodule

// File: tb/tb_vga_fb_writer.sv
// Directed and randomised-backpressure bench for vga_fb_writer with a pixel scoreboard.
module tb_vga_fb_writer;

  localparam logic [31:0] Base    = 32'h4000_0000;
  localparam int unsigned FbWords = 153600;
  localparam int unsigned Depth   = 8;
  localparam logic [31:0] WinEnd  = 32'h4009_6000;

  logic        ACLK = 1'b0;
  logic        RESET_N;
  logic [31:0] DATA_I;
  logic [31:0] ADDR;
  logic        WRSTB;
  logic        STALL;
  logic        SRAM_WR_VALID;
  logic        SRAM_WR_READY;
  logic [19:0] SRAM_WR_ADDR;
  logic [15:0] SRAM_WR_DATA;
  logic        OVERFLOW;
  logic        CLR_FLAGS;
  logic [3:0]  FIFO_COUNT;

  int          n_tests = 0;
  int          n_fail = 0;
  int          n_writes = 0;
  logic [35:0] exp_q[$];
  logic        prev_hold = 1'b0;
  logic [19:0] prev_addr;
  logic [15:0] prev_data;

  int          base_w;
  int          issued;
  int          cycles;
  int unsigned idx;
  logic [31:0] a;
  logic [31:0] d;

  vga_fb_writer #(
    .BASEADDRESS(Base),
    .FbWords    (FbWords),
    .Depth      (Depth)
  ) dut (
    .ACLK         (ACLK),
    .RESET_N      (RESET_N),
    .DATA_I       (DATA_I),
    .ADDR         (ADDR),
    .WRSTB        (WRSTB),
    .STALL        (STALL),
    .SRAM_WR_VALID(SRAM_WR_VALID),
    .SRAM_WR_READY(SRAM_WR_READY),
    .SRAM_WR_ADDR (SRAM_WR_ADDR),
    .SRAM_WR_DATA (SRAM_WR_DATA),
    .OVERFLOW     (OVERFLOW),
    .CLR_FLAGS    (CLR_FLAGS),
    .FIFO_COUNT   (FIFO_COUNT)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic expect_word(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] off;
    logic [18:0] wi;
    off = addr - Base;
    wi  = off[20:2];
    exp_q.push_back({wi, 1'b0, data[15:0]});
    exp_q.push_back({wi, 1'b1, data[31:16]});
  endtask

  task automatic wait_drain(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      if (FIFO_COUNT == 4'd0 && !SRAM_WR_VALID) done = 1'b1;
      else tick();
    end
    check(tag, 64'(done), 64'd1);
  endtask

  // Pixel scoreboard and backpressure-stability monitor, sampled mid-cycle.
  always @(negedge ACLK) begin
    if (RESET_N && SRAM_WR_VALID && SRAM_WR_READY) begin
      n_writes <= n_writes + 1;
      check("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("write_pixel", {SRAM_WR_ADDR, SRAM_WR_DATA}, exp_q.pop_front());
    end
    if (RESET_N && prev_hold) begin
      check("hold_valid", 64'(SRAM_WR_VALID), 64'd1);
      check("hold_addr", 64'(SRAM_WR_ADDR), 64'(prev_addr));
      check("hold_data", 64'(SRAM_WR_DATA), 64'(prev_data));
    end
    prev_hold <= RESET_N && SRAM_WR_VALID && !SRAM_WR_READY;
    prev_addr <= SRAM_WR_ADDR;
    prev_data <= SRAM_WR_DATA;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0; DATA_I = '0; ADDR = '0; WRSTB = 1'b0;
    SRAM_WR_READY = 1'b0; CLR_FLAGS = 1'b0;
    #2;
    check("rst_valid", 64'(SRAM_WR_VALID), 64'd0);
    check("rst_addr", 64'(SRAM_WR_ADDR), 64'd0);
    check("rst_data", 64'(SRAM_WR_DATA), 64'd0);
    check("rst_count", 64'(FIFO_COUNT), 64'd0);
    check("rst_stall", 64'(STALL), 64'd0);
    check("rst_ovf", 64'(OVERFLOW), 64'd0);
    repeat (2) @(posedge ACLK);
    #1 RESET_N = 1'b1;
    tick();

    // Single store: latency and half ordering.
    SRAM_WR_READY = 1'b1;
    ADDR = 32'h4000_0008; DATA_I = 32'h7FFF_001F; WRSTB = 1'b1;
    expect_word(ADDR, DATA_I);
    tick();
    WRSTB = 1'b0;
    check("single_count1", 64'(FIFO_COUNT), 64'd1);
    check("single_valid0", 64'(SRAM_WR_VALID), 64'd0);
    tick();
    check("single_lo_valid", 64'(SRAM_WR_VALID), 64'd1);
    check("single_lo_addr", 64'(SRAM_WR_ADDR), 64'd4);
    check("single_lo_data", 64'(SRAM_WR_DATA), 64'h001F);
    tick();
    check("single_hi_addr", 64'(SRAM_WR_ADDR), 64'd5);
    check("single_hi_data", 64'(SRAM_WR_DATA), 64'h7FFF);
    tick();
    check("single_done_valid", 64'(SRAM_WR_VALID), 64'd0);
    check("single_done_count", 64'(FIFO_COUNT), 64'd0);

    // Out-of-window and misaligned stores are ignored.
    base_w = n_writes;
    for (int k = 0; k < 3; k++) begin
      ADDR = (k == 0) ? 32'h3FFF_FFFC : (k == 1) ? 32'h4000_0002 : WinEnd;
      DATA_I = 32'hDEAD_BEEF; WRSTB = 1'b1;
      tick();
      WRSTB = 1'b0;
      tick();
      check("miss_count", 64'(FIFO_COUNT), 64'd0);
      check("miss_valid", 64'(SRAM_WR_VALID), 64'd0);
    end
    check("miss_ovf", 64'(OVERFLOW), 64'd0);
    check("miss_writes", 64'(n_writes), 64'(base_w));

    // Fill with READY low, drop the ninth, then drain.
    SRAM_WR_READY = 1'b0;
    base_w = n_writes;
    for (int k = 0; k < 9; k++) begin
      ADDR = Base + 32'(64 + 4 * k);
      DATA_I = {16'h1000 + 16'(k), 16'h2000 + 16'(k)};
      WRSTB = 1'b1;
      if (k < 8) expect_word(ADDR, DATA_I);
      tick();
      if (k == 6) check("fill7_stall", 64'(STALL), 64'd0);
      if (k == 7) begin
        check("fill8_stall", 64'(STALL), 64'd1);
        check("fill8_count", 64'(FIFO_COUNT), 64'd8);
        check("fill8_ovf", 64'(OVERFLOW), 64'd0);
      end
    end
    WRSTB = 1'b0;
    check("drop_ovf", 64'(OVERFLOW), 64'd1);
    check("drop_count", 64'(FIFO_COUNT), 64'd8);
    check("bp_no_writes", 64'(n_writes), 64'(base_w));
    SRAM_WR_READY = 1'b1;
    wait_drain("drain_fill", 60);
    check("drain_16_writes", 64'(n_writes - base_w), 64'd16);
    check("drain_q_empty", 64'(exp_q.size()), 64'd0);
    check("ovf_sticky", 64'(OVERFLOW), 64'd1);
    CLR_FLAGS = 1'b1;
    tick();
    CLR_FLAGS = 1'b0;
    check("ovf_cleared", 64'(OVERFLOW), 64'd0);

    // Full FIFO, HIGH-half retire coinciding with a new hit.
    SRAM_WR_READY = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ADDR = Base + 32'(256 + 4 * k); DATA_I = {16'h3000 + 16'(k), 16'h4000 + 16'(k)};
      WRSTB = 1'b1;
      expect_word(ADDR, DATA_I);
      tick();
    end
    WRSTB = 1'b0;
    check("full2_count", 64'(FIFO_COUNT), 64'd8);
    SRAM_WR_READY = 1'b1;
    tick();
    check("full2_in_high", 64'(SRAM_WR_ADDR[0]), 64'd1);
    ADDR = Base + 32'h400; DATA_I = 32'h5555_AAAA; WRSTB = 1'b1;
    expect_word(ADDR, DATA_I);
    tick();
    WRSTB = 1'b0; SRAM_WR_READY = 1'b0;
    check("pushpop_count", 64'(FIFO_COUNT), 64'd8);
    check("pushpop_ovf", 64'(OVERFLOW), 64'd0);
    check("pushpop_stall", 64'(STALL), 64'd1);
    SRAM_WR_READY = 1'b1;
    wait_drain("drain_pushpop", 60);
    check("pushpop_q_empty", 64'(exp_q.size()), 64'd0);

    // Random backpressure over 1000 stores.
    issued = 0; cycles = 0;
    while (issued < 1000 && cycles < 20000) begin
      SRAM_WR_READY = 1'($urandom_range(0, 1));
      if (!STALL && $urandom_range(0, 3) != 0) begin
        idx = $urandom_range(0, FbWords - 1);
        a = Base + 32'(idx * 4);
        d = $urandom;
        ADDR = a; DATA_I = d; WRSTB = 1'b1;
        expect_word(a, d);
        issued++;
      end else begin
        WRSTB = 1'b0;
      end
      tick();
      cycles++;
    end
    WRSTB = 1'b0;
    check("rand_issued", 64'(issued), 64'd1000);
    SRAM_WR_READY = 1'b1;
    wait_drain("drain_rand", 100);
    check("rand_q_empty", 64'(exp_q.size()), 64'd0);
    check("rand_ovf", 64'(OVERFLOW), 64'd0);

    // Reset mid-drain with five words queued, in the HIGH half.
    SRAM_WR_READY = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ADDR = Base + 32'(512 + 4 * k); DATA_I = {16'h6000 + 16'(k), 16'h7000 + 16'(k)};
      WRSTB = 1'b1;
      expect_word(ADDR, DATA_I);
      tick();
    end
    WRSTB = 1'b0;
    tick();
    SRAM_WR_READY = 1'b1;
    tick();
    SRAM_WR_READY = 1'b0;
    check("prerst_high", 64'(SRAM_WR_ADDR[0]), 64'd1);
    check("prerst_count", 64'(FIFO_COUNT), 64'd5);
    #2 RESET_N = 1'b0;
    #1;
    check("arst_valid", 64'(SRAM_WR_VALID), 64'd0);
    check("arst_addr", 64'(SRAM_WR_ADDR), 64'd0);
    check("arst_data", 64'(SRAM_WR_DATA), 64'd0);
    check("arst_count", 64'(FIFO_COUNT), 64'd0);
    check("arst_stall", 64'(STALL), 64'd0);
    exp_q.delete();
    base_w = n_writes;
    repeat (2) @(posedge ACLK);
    #1 RESET_N = 1'b1;
    SRAM_WR_READY = 1'b1;
    repeat (10) tick();
    check("postrst_writes", 64'(n_writes), 64'(base_w));
    check("postrst_valid", 64'(SRAM_WR_VALID), 64'd0);
    check("postrst_count", 64'(FIFO_COUNT), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
